systolic_seq_ctrl: RTL and testbench
====================================

# systolic_seq_ctrl

Instruction sequencer for a `row` x `col` array of MAC tiles that supports both dataflows: weight-stationary (format=1) and output-stationary (format=0). On a `start` request it issues row-skewed `inst_w` pairs, the `overwrite` re-arm pulse, the `flush` drain window and activation-memory read requests. It sits between the top-level core controller and the PE array's west edge and north/flush controls, and it provides the array's only source of instruction timing.

## Interface
Parameters:
- `row`, 8, number of PE rows (one `inst_w` pair per row).
- `col`, 8, number of PE columns (number of weight-load cycles in WS).
- `cnt_bw`, 8, width of `num_vec`.
- `addr_bw`, 11, width of `act_rd_addr`.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `format_in`  in  1  dataflow for the job: 1 = WS, 0 = OS; latched on accepted start.
- `num_vec`  in  cnt_bw  activation vectors in the job; latched on accepted start.
- `format`  out  1  latched dataflow, held until the next accepted start.
- `inst_w`  out  2*row  row r uses bits [2r+1:2r]: bit0 = load/compute, bit1 = execute.
- `overwrite`  out  1  re-arms PE weight loading (WS only).
- `flush`  out  1  OS psum drain enable.
- `act_rd_en`  out  1  activation/weight memory read strobe.
- `act_rd_addr`  out  addr_bw  read address.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle job-complete pulse.

## Operation
- States: IDLE, ARM, LOAD, EXEC, SKEW, DRAIN, DONE.
- The state sets a base instruction `b`: 01 in LOAD, 10 in EXEC with WS, 01 in EXEC with OS, 00 in every other state.
- IDLE with `start`=1:
  - latches `format_in` and `num_vec`, and clears the address counter;
  - goes to DONE if `num_vec`=0;
  - otherwise goes to ARM if `format_in`=1, or to EXEC if `format_in`=0.
- ARM: 1 cycle with `overwrite`=1, then LOAD.
- LOAD: `col` cycles, then EXEC.
- EXEC: `num_vec` cycles, then SKEW.
- SKEW: `row` cycles with `b`=00, so the skewed rows can retire. Next state is DONE in WS, DRAIN in OS.
- DRAIN (OS only): `row` cycles with `flush`=1, then DONE.
- DONE: 1 cycle with `done`=1, then IDLE.
- `act_rd_en`=1 exactly when `b`≠00. `act_rd_addr` shows the counter value; the counter increments after each strobe. Address sequence:
  - WS: 0 .. col+num_vec−1 (weights first, then activations);
  - OS: 0 .. num_vec−1.
- The address counter wraps modulo 2^addr_bw. No error is flagged on wrap.
- Skew: `inst_w` row 0 equals `b` delayed 1 cycle, which matches the 1-cycle memory read latency. Row r equals row 0 delayed r cycles, through a per-row register chain.
- `start` is ignored while `busy`=1. It is not queued.
- `format` does not change mid-job.
- `flush` and `overwrite` are never high at the same time. `flush` is never high in WS; `overwrite` is never high in OS.
- Cycle and state counters are `cnt_bw` bits wide, or wide enough for max(row, col), whichever is larger.

## Timing
- Reset, including mid-job:
  - state goes to IDLE and every skew register to 0;
  - the next cycle shows `inst_w`=0, `overwrite`=`flush`=`act_rd_en`=0, `act_rd_addr`=0, `busy`=`done`=0 and `format`=0;
  - no `done` pulse is produced for an aborted job.
- Start accepted in cycle 0, WS, N=`num_vec`:
  - ARM in cycle 1;
  - LOAD in cycles 2..col+1;
  - EXEC in cycles col+2..col+N+1;
  - SKEW in cycles col+N+2..col+N+row+1;
  - `done` in cycle col+N+row+2.
- Start accepted in cycle 0, OS:
  - EXEC in cycles 1..N;
  - SKEW in cycles N+1..N+row;
  - DRAIN in cycles N+row+1..N+2·row;
  - `done` in cycle N+2·row+1.
- `busy` goes high the cycle after start is accepted and drops the cycle after `done`.
- A `start` in the same cycle as `done` is ignored. A `start` in the first IDLE cycle after `done` is accepted.
- The last row's final nonzero `inst_w` occurs in the last SKEW cycle. Every `inst_w` is 0 in DRAIN and DONE.

## Test plan
- Reset, then idle for 5 cycles: all outputs 0. Pulse `start` with `busy`=0 and `num_vec`=0: `busy` high in cycle 1, `done`=1 in cycle 1, `act_rd_en` never asserted.
- WS, row=col=8, N=16, start at cycle 0:
  - `overwrite` only at cycle 1;
  - `inst_w[1:0]`=01 in cycles 3..10 and 10 in cycles 11..26;
  - `inst_w[15:14]` is the same pattern 7 cycles later;
  - addresses 0..23 in cycles 2..25;
  - `done` at cycle 34.
- OS, row=col=8, N=16, start at 0:
  - `inst_w[1:0]`=01 in cycles 2..17;
  - `flush` high in cycles 25..32;
  - `done` at cycle 33;
  - `overwrite` never high.
- Pulse `start` every cycle during an OS job: exactly one `done`, and `format` is unchanged. The back-to-back restart is accepted the cycle after `done`.
- Assert `reset` in the middle of EXEC of a WS job: next cycle all outputs 0, and no `done`. A fresh OS start then completes on the nominal schedule.
- Set `addr_bw`=4 and run OS with N=20: the address wraps 15→0, and `done` arrives on schedule.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: row-skewed instruction, overwrite, flush and read-address sequencer for a WS/OS MAC array
module systolic_seq_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int cnt_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 format_in,
    input  logic [cnt_bw-1:0]    num_vec,
    output logic                 format,
    output logic [2*row-1:0]     inst_w,
    output logic                 overwrite,
    output logic                 flush,
    output logic                 act_rd_en,
    output logic [addr_bw-1:0]   act_rd_addr,
    output logic                 busy,
    output logic                 done
);
    localparam int mx = row > col ? row : col;
    localparam int cw = cnt_bw > $clog2(mx + 1) ? cnt_bw : $clog2(mx + 1);

    typedef enum logic [2:0] {IDLE, ARM, LOAD, EXEC, SKEW, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [cw-1:0]      cnt_q, cnt_d, lim;
    logic [cnt_bw-1:0]  num_q;
    logic [addr_bw-1:0] addr_q;
    logic               fmt_q, ow_q, fl_q, busy_q, done_q, last, accept;
    logic [1:0]         b;
    logic [1:0]         skew_q [row];

    // base instruction, length of the current segment and next state
    always_comb begin
        b = state_q == LOAD ? 2'b01 : state_q == EXEC ? (fmt_q ? 2'b10 : 2'b01) : 2'b00;
        lim = state_q == LOAD ? cw'(col) : state_q == EXEC ? cw'(num_q) : cw'(row);
        last = cnt_q == lim - cw'(1);
        accept = state_q == IDLE && start;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !start ? IDLE : num_vec == '0 ? DONE : format_in ? ARM : EXEC;
            ARM:     state_d = LOAD;
            LOAD:    state_d = last ? EXEC : LOAD;
            EXEC:    state_d = last ? SKEW : EXEC;
            SKEW:    state_d = !last ? SKEW : fmt_q ? DONE : DRAIN;
            DRAIN:   state_d = last ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
        cnt_d = state_d == state_q ? cnt_q + cw'(1) : '0;
    end

    // FSM state, job latches, address counter and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            fmt_q   <= 1'b0;
            addr_q  <= '0;
            ow_q    <= 1'b0;
            fl_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                fmt_q <= format_in;
                num_q <= num_vec;
            end
            addr_q <= accept ? '0 : act_rd_en ? addr_q + addr_bw'(1) : addr_q;
            ow_q   <= state_d == ARM;
            fl_q   <= state_d == DRAIN;
            busy_q <= state_d != IDLE;
            done_q <= state_d == DONE;
        end
    end

    // skew chain: row 0 sees b one cycle late (read latency), row r a further r cycles later
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < row; r++) skew_q[r] <= 2'b00;
        end else begin
            skew_q[0] <= b;
            for (int r = 1; r < row; r++) skew_q[r] <= skew_q[r-1];
        end
    end

    for (genvar i = 0; i < row; i++) begin : g_row
        assign inst_w[2*i+:2] = skew_q[i];
    end

    assign format      = fmt_q;
    assign overwrite   = ow_q;
    assign flush       = fl_q;
    assign act_rd_en   = b != 2'b00;
    assign act_rd_addr = addr_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: schedule-based reference model checks of the systolic sequencer
module tb_systolic_seq_ctrl;
    localparam int ROW = 8;
    localparam int COL = 8;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, format_in = 1'b0;
    logic [7:0]  num_vec = '0;
    logic        fmt_o, ow, fl, en, busy, dn;
    logic        fmt4, ow4, fl4, en4, busy4, dn4;
    logic [15:0] iw, iw4;
    logic [10:0] addr;
    logic [3:0]  addr4;
    logic [21:0] obs, obs4;
    int          checks = 0, fails = 0;
    bit          m_valid = 1'b0, m_f = 1'b0, m_fmt = 1'b0;
    int          m_n = 0, m_t = 0;

    assign obs  = {fmt_o, iw, ow, fl, en, busy, dn};
    assign obs4 = {fmt4, iw4, ow4, fl4, en4, busy4, dn4};

    always #5 clk = ~clk;

    systolic_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .format_in(format_in), .num_vec(num_vec),
        .format(fmt_o), .inst_w(iw), .overwrite(ow), .flush(fl), .act_rd_en(en),
        .act_rd_addr(addr), .busy(busy), .done(dn)
    );

    systolic_seq_ctrl #(.addr_bw(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .format_in(format_in), .num_vec(num_vec),
        .format(fmt4), .inst_w(iw4), .overwrite(ow4), .flush(fl4), .act_rd_en(en4),
        .act_rd_addr(addr4), .busy(busy4), .done(dn4)
    );

    // base instruction at job-relative cycle t (start accepted at t=0)
    function automatic logic [1:0] bfun(bit f, int n, int t);
        if (n == 0) return 2'b00;
        if (f) return (t >= 2 && t <= COL + 1) ? 2'b01 : (t >= COL + 2 && t <= COL + n + 1) ? 2'b10 : 2'b00;
        return (t >= 1 && t <= n) ? 2'b01 : 2'b00;
    endfunction

    function automatic int done_t(bit f, int n);
        return n == 0 ? 1 : f ? COL + n + ROW + 2 : n + 2 * ROW + 1;
    endfunction

    function automatic bit exp_busy();
        return m_valid && m_t >= 1 && m_t <= done_t(m_f, m_n);
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [15:0] e_iw;
        e_iw = '0;
        if (m_valid) for (int r = 0; r < ROW; r++) e_iw[2*r+:2] = bfun(m_f, m_n, m_t - 1 - r);
        return {m_fmt, e_iw,
                m_valid && m_f && m_n != 0 && m_t == 1,
                m_valid && !m_f && m_n != 0 && m_t >= m_n + ROW + 1 && m_t <= m_n + 2 * ROW,
                m_valid && bfun(m_f, m_n, m_t) != 2'b00,
                exp_busy(),
                m_valid && m_t == done_t(m_f, m_n)};
    endfunction

    function automatic int exp_addr();
        return m_f ? m_t - 2 : m_t - 1;
    endfunction

    // reference job tracker: accepts start only when the model says idle
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_fmt   <= 1'b0;
        end else if (start && !exp_busy()) begin
            m_valid <= 1'b1;
            m_f     <= format_in;
            m_fmt   <= format_in;
            m_n     <= int'(num_vec);
            m_t     <= 1;
        end else if (m_valid && m_t < 1000) begin
            m_t <= m_t + 1;
        end
    end

    task automatic test_reset();
        logic [21:0] e;
        int en_cnt = 0, dcyc = -1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL reset_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            checks++;
            if (c < 7 && (addr !== 11'd0 || addr4 !== 4'd0)) begin fails++; $display("FAIL reset_addr cyc=%0d got=%0d/%0d expected=0", c, addr, addr4); end
            if (en) en_cnt++;
            if (dn && dcyc < 0) dcyc = c;
            reset = c < 1;
            start = c == 7;
            format_in = 1'b1;
            num_vec = 8'd0;
        end
        checks++;
        if (en_cnt != 0) begin fails++; $display("FAIL zero_job_rd_en got=%0d strobes expected=0", en_cnt); end
        checks++;
        if (dcyc != 8) begin fails++; $display("FAIL zero_job_done got cyc=%0d expected=8", dcyc); end
    endtask

    task automatic test_ws();
        logic [21:0] e;
        int dcyc = -1, ow_cnt = 0, ow_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL ws_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            if (e[2]) begin
                checks++;
                if (addr !== 11'(exp_addr()) || addr4 !== 4'(exp_addr())) begin fails++; $display("FAIL ws_addr cyc=%0d got=%0d/%0d expected=%0d", c, addr, addr4, exp_addr()); end
            end
            if (dn && dcyc < 0) dcyc = c;
            if (ow) begin ow_cnt++; ow_cyc = c; end
            start = c == 0;
            format_in = 1'b1;
            num_vec = 8'd16;
        end
        checks++;
        if (dcyc != 34) begin fails++; $display("FAIL ws_done got cyc=%0d expected=34", dcyc); end
        checks++;
        if (ow_cnt != 1 || ow_cyc != 1) begin fails++; $display("FAIL ws_overwrite got %0d pulses at cyc=%0d expected 1 at cyc=1", ow_cnt, ow_cyc); end
    endtask

    task automatic test_os();
        logic [21:0] e;
        int dcyc = -1, ow_cnt = 0, fl_cnt = 0, fl_first = -1;
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL os_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            if (e[2]) begin
                checks++;
                if (addr !== 11'(exp_addr()) || addr4 !== 4'(exp_addr())) begin fails++; $display("FAIL os_addr cyc=%0d got=%0d/%0d expected=%0d", c, addr, addr4, exp_addr()); end
            end
            if (dn && dcyc < 0) dcyc = c;
            if (ow) ow_cnt++;
            if (fl) begin fl_cnt++; if (fl_first < 0) fl_first = c; end
            start = c == 0;
            format_in = 1'b0;
            num_vec = 8'd16;
        end
        checks++;
        if (dcyc != 33) begin fails++; $display("FAIL os_done got cyc=%0d expected=33", dcyc); end
        checks++;
        if (fl_cnt != 8 || fl_first != 25 || ow_cnt != 0) begin fails++; $display("FAIL os_flush got %0d flush from cyc=%0d, %0d overwrite expected 8 from 25, 0", fl_cnt, fl_first, ow_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [21:0] e;
        int d_cnt = 0, fmt_bad = 0;
        logic b24 = 1'b0;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL b2b_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            if (e[2]) begin
                checks++;
                if (addr !== 11'(exp_addr()) || addr4 !== 4'(exp_addr())) begin fails++; $display("FAIL b2b_addr cyc=%0d got=%0d/%0d expected=%0d", c, addr, addr4, exp_addr()); end
            end
            if (c < 30 && dn) d_cnt++;
            if (c >= 1 && c <= 23 && fmt_o !== 1'b0) fmt_bad++;
            if (c == 24) b24 = busy;
            start = c < 30;
            format_in = c == 0 ? 1'b0 : 1'($urandom);
            num_vec = c == 0 ? 8'd5 : 8'($urandom_range(1, 20));
        end
        checks++;
        if (d_cnt != 1) begin fails++; $display("FAIL b2b_done_count got=%0d expected=1", d_cnt); end
        checks++;
        if (fmt_bad != 0) begin fails++; $display("FAIL b2b_format_stable got %0d changed cycles expected=0", fmt_bad); end
        checks++;
        if (b24 !== 1'b1) begin fails++; $display("FAIL b2b_restart busy@24 got=%b expected=1", b24); end
    endtask

    task automatic test_reset_mid();
        logic [21:0] e;
        int dcyc = -1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL rstmid_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            if (e[2]) begin
                checks++;
                if (addr !== 11'(exp_addr()) || addr4 !== 4'(exp_addr())) begin fails++; $display("FAIL rstmid_addr cyc=%0d got=%0d/%0d expected=%0d", c, addr, addr4, exp_addr()); end
            end
            if (dn && dcyc < 0) dcyc = c;
            reset = c == 15;
            start = c == 0 || c == 20;
            format_in = c == 0;
            num_vec = c == 0 ? 8'd16 : 8'd7;
        end
        checks++;
        if (dcyc != 44) begin fails++; $display("FAIL rstmid_done got first done cyc=%0d expected=44", dcyc); end
    endtask

    task automatic test_wrap();
        logic [21:0] e;
        int dcyc = -1;
        bit wrapped = 1'b0, p_en = 1'b0;
        logic [3:0] p_addr = '0;
        for (int c = 0; c < 47; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL wrap_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            if (e[2]) begin
                checks++;
                if (addr !== 11'(exp_addr()) || addr4 !== 4'(exp_addr())) begin fails++; $display("FAIL wrap_addr cyc=%0d got=%0d/%0d expected=%0d", c, addr, addr4, exp_addr()); end
            end
            if (en4 && p_en && p_addr == 4'd15 && addr4 == 4'd0) wrapped = 1'b1;
            p_en = en4;
            p_addr = addr4;
            if (dn4 && dcyc < 0) dcyc = c;
            start = c == 0;
            format_in = 1'b0;
            num_vec = 8'd20;
        end
        checks++;
        if (!wrapped) begin fails++; $display("FAIL wrap_seen got=0 expected=1"); end
        checks++;
        if (dcyc != 37) begin fails++; $display("FAIL wrap_done got cyc=%0d expected=37", dcyc); end
    endtask

    task automatic test_random();
        logic [21:0] e;
        for (int c = 0; c < 660; c++) begin
            @(negedge clk);
            e = exp_vec();
            checks++;
            if (obs !== e || obs4 !== e) begin fails++; $display("FAIL rand_outputs cyc=%0d got=%h/%h expected=%h", c, obs, obs4, e); end
            if (e[2]) begin
                checks++;
                if (addr !== 11'(exp_addr()) || addr4 !== 4'(exp_addr())) begin fails++; $display("FAIL rand_addr cyc=%0d got=%0d/%0d expected=%0d", c, addr, addr4, exp_addr()); end
            end
            start = c < 600 && $urandom_range(0, 5) == 0;
            reset = c < 600 && $urandom_range(0, 150) == 0;
            format_in = 1'($urandom);
            num_vec = 8'($urandom_range(0, 24));
        end
    endtask

    initial begin
        test_reset();
        test_ws();
        test_os();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
